// File: rtl/uart_tx.sv
// Byte serialiser: start bit, 8 data bits LSB first, optional even parity, 1-2 stop bits.
// BIST mode steers the frame onto the loopback line instead of the external pin.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       ClK,
  input  logic       Clear,
  input  logic       Transmit_Start,
  input  logic [7:0] Tx_Data,
  input  logic       BIST_Mode,
  output logic       Tx_Serial,
  output logic       Loop_Serial,
  output logic       Tx_Busy,
  output logic       Tx_Done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BMAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic          scnt_q, scnt_d;
  logic [7:0]    data_q, data_d;
  logic          mode_q, mode_d;
  logic          sbit_q, sbit_d;
  logic          tx_q, tx_d;
  logic          loop_q, loop_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          boundary;

  always_comb begin
    state_d  = state_q;
    bidx_d   = bidx_q;
    scnt_d   = scnt_q;
    data_d   = data_q;
    mode_d   = mode_q;
    sbit_d   = sbit_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    boundary = (bcnt_q == BMAX);
    bcnt_d   = boundary ? '0 : bcnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        bcnt_d = '0;
        if (Transmit_Start) begin
          state_d = START;
          data_d  = Tx_Data;
          mode_d  = BIST_Mode;
          bidx_d  = 3'd0;
          scnt_d  = 1'b0;
          sbit_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (boundary) begin
          state_d = DATA;
          bidx_d  = 3'd0;
          sbit_d  = data_q[0];
        end
      end
      DATA: begin
        if (boundary) begin
          if (bidx_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              sbit_d  = ^data_q;
            end else begin
              state_d = STOP;
              scnt_d  = 1'b0;
              sbit_d  = 1'b1;
            end
          end else begin
            bidx_d = bidx_q + 3'd1;
            sbit_d = data_q[bidx_q + 3'd1];
          end
        end
      end
      PARITY: begin
        if (boundary) begin
          state_d = STOP;
          scnt_d  = 1'b0;
          sbit_d  = 1'b1;
        end
      end
      STOP: begin
        if (boundary) begin
          if (scnt_q == 1'(STOP_BITS - 1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            scnt_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Route from the next-state mode so both lines switch cleanly on the accepting edge.
    tx_d   = mode_d ? 1'b1 : sbit_d;
    loop_d = mode_d ? sbit_d : 1'b1;
  end

  always_ff @(posedge ClK or posedge Clear) begin
    if (Clear) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      bidx_q  <= 3'd0;
      scnt_q  <= 1'b0;
      data_q  <= 8'd0;
      mode_q  <= 1'b0;
      sbit_q  <= 1'b1;
      tx_q    <= 1'b1;
      loop_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      bidx_q  <= bidx_d;
      scnt_q  <= scnt_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      sbit_q  <= sbit_d;
      tx_q    <= tx_d;
      loop_q  <= loop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Tx_Serial   = tx_q;
  assign Loop_Serial = loop_q;
  assign Tx_Busy     = busy_q;
  assign Tx_Done     = done_q;

endmodule
